// File: rtl/amo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amo_pkg
// Description : Shared types for the A-extension bus initiator: operation
//               codes, FSM state encoding and address-tag field values.
// Revision    : 1.0  initial release
// ============================================================================
package amo_pkg;

   // Operation requested by execute (4-bit encoding)
   typedef enum logic [3:0] {
      OP_LR   = 4'd0,
      OP_SC   = 4'd1,
      OP_SWAP = 4'd2,
      OP_ADD  = 4'd3,
      OP_XOR  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_MIN  = 4'd7,
      OP_MAX  = 4'd8,
      OP_MINU = 4'd9,
      OP_MAXU = 4'd10
   } amo_op_t;

   localparam int AMO_OPS_COUNT = 11;

   // Initiator sequencing states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CALC = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } amo_state_t;

   // Address tag = {mode[1:0], lock/unlock}; {NONE,LOCK} encodes as all zeros
   localparam logic [1:0] TAG_MODE_NONE = 2'b00;
   localparam logic [1:0] TAG_MODE_LRSC = 2'b01;
   localparam logic [1:0] TAG_MODE_AMO  = 2'b10;
   localparam logic       TAG_LOCK      = 1'b0;
   localparam logic       TAG_UNLOCK    = 1'b1;

   // True for read-modify-write operations (everything except LR/SC)
   function automatic logic is_amo(input amo_op_t op);
      return (op != OP_LR) && (op != OP_SC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : amo_alu
// Description : Combinational AMO combine function, new = f(old, rs2).
//               32-bit wrap-around, no flags; ties keep the old value.
// Revision    : 1.0  initial release
// ============================================================================
module amo_alu
   import amo_pkg::*;
(
   input  amo_op_t     op_i,
   input  logic [31:0] a_i,    // old memory word
   input  logic [31:0] b_i,    // rs2 operand
   output logic [31:0] y_o
);

   // Select the combined value; LR/SC and unknown codes pass the old word through
   always_comb begin
      y_o = a_i;
      case (op_i)
         OP_SWAP: y_o = b_i;
         OP_ADD:  y_o = a_i + b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_MIN:  y_o = ($signed(b_i) < $signed(a_i)) ? b_i : a_i;
         OP_MAX:  y_o = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;
         OP_MINU: y_o = (b_i < a_i) ? b_i : a_i;
         OP_MAXU: y_o = (b_i > a_i) ? b_i : a_i;
         default: y_o = a_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/atomic_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : atomic_mem_master
// Description : Wishbone initiator for LR.W / SC.W / AMO*.W. Issues tagged
//               lock/unlock bus cycles, holds the bus between the AMO read
//               and write, and returns the rd value with a done pulse.
// Revision    : 1.0  initial release
// ============================================================================
module atomic_mem_master
   import amo_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  amo_op_t     op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic        misaligned_o,
   output logic        timeout_o,
   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_addr_o,
   output logic [2:0]  mem_addr_tag_o,
   output logic [31:0] mem_data_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   input  logic        mem_data_tag_i
);

   // Last timer value before abort; only meaningful when WAIT_TIMEOUT != 0
   localparam logic [31:0] TMO_LAST = 32'(WAIT_TIMEOUT - 1);

   amo_state_t  state_q, state_d;
   amo_op_t     op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;      // rs2 / SC store data
   logic [31:0] rdata_q, rdata_d;    // word returned by the lock read
   logic [31:0] timer_q, timer_d;
   logic        sc_tag_q, sc_tag_d;
   logic        mis_q, mis_d;
   logic        tmo_q, tmo_d;

   logic [31:0] w_alu_y;
   logic        w_timer_hit;
   logic [1:0]  w_mode;

   amo_alu u_alu (
      .op_i (op_q),
      .a_i  (rdata_q),
      .b_i  (data_q),
      .y_o  (w_alu_y)
   );

   assign w_timer_hit = (WAIT_TIMEOUT != 0) && (timer_q == TMO_LAST);
   assign w_mode      = is_amo(op_q) ? TAG_MODE_AMO : TAG_MODE_LRSC;

   // State and datapath registers; reset drops any in-flight operation
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_LR;
         addr_q   <= '0;
         data_q   <= '0;
         rdata_q  <= '0;
         timer_q  <= '0;
         sc_tag_q <= 1'b0;
         mis_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         rdata_q  <= rdata_d;
         timer_q  <= timer_d;
         sc_tag_q <= sc_tag_d;
         mis_q    <= mis_d;
         tmo_q    <= tmo_d;
      end
   end

   // Next-state, request latching, ack sampling and wait-timer control
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rdata_d  = rdata_q;
      timer_d  = timer_q;
      sc_tag_d = sc_tag_q;
      mis_d    = mis_q;
      tmo_d    = tmo_q;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (req_i) begin
               op_d     = op_i;
               addr_d   = addr_i;
               data_d   = data_i;
               rdata_d  = '0;
               sc_tag_d = 1'b0;
               mis_d    = 1'b0;
               tmo_d    = 1'b0;
               if (addr_i[1:0] != 2'b00) begin
                  mis_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (op_i == OP_SC) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (mem_ack_i) begin
               rdata_d = mem_data_i;
               timer_d = '0;
               state_d = is_amo(op_q) ? ST_CALC : ST_DONE;
            end else if (w_timer_hit) begin
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_CALC: begin
            timer_d = '0;
            state_d = ST_WR;
         end
         ST_WR: begin
            if (mem_ack_i) begin
               if (op_q == OP_SC) sc_tag_d = mem_data_tag_i;
               timer_d = '0;
               state_d = ST_DONE;
            end else if (w_timer_hit) begin
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs: bus signals and completion decoded from the current state
   always_comb begin
      busy_o         = (state_q != ST_IDLE);
      done_o         = 1'b0;
      result_o       = '0;
      misaligned_o   = 1'b0;
      timeout_o      = 1'b0;
      mem_cyc_o      = 1'b0;
      mem_stb_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_tag_o = {TAG_MODE_NONE, TAG_LOCK};
      mem_data_o     = '0;
      mem_addr_o     = addr_q;
      case (state_q)
         ST_RD: begin
            mem_cyc_o      = 1'b1;
            mem_stb_o      = 1'b1;
            mem_addr_tag_o = {w_mode, TAG_LOCK};
         end
         ST_CALC: begin
            // Bus stays owned between the lock read and the unlock write
            mem_cyc_o      = 1'b1;
            mem_addr_tag_o = {w_mode, TAG_LOCK};
         end
         ST_WR: begin
            mem_cyc_o      = 1'b1;
            mem_stb_o      = 1'b1;
            mem_we_o       = 1'b1;
            mem_addr_tag_o = {w_mode, TAG_UNLOCK};
            mem_data_o     = (op_q == OP_SC) ? data_q : w_alu_y;
         end
         ST_DONE: begin
            done_o       = 1'b1;
            misaligned_o = mis_q;
            timeout_o    = tmo_q;
            if (mis_q || tmo_q)    result_o = '0;
            else if (op_q == OP_SC) result_o = {31'b0, sc_tag_q};
            else                   result_o = rdata_q;
         end
         default: ;
      endcase
      mem_sel_o = {4{mem_cyc_o}};
   end

endmodule
`default_nettype wire

// File: tb/tb_atomic_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_atomic_mem_master
// Description : Directed self-checking bench with a small tagged memory and
//               LR/SC reservation model acting as the Wishbone responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_atomic_mem_master;
   import amo_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   amo_op_t     op_i  = OP_LR;
   logic [31:0] addr_i = '0;
   logic [31:0] data_i = '0;
   logic        busy_o, done_o, misaligned_o, timeout_o;
   logic [31:0] result_o;
   logic        mem_cyc_o, mem_stb_o, mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o, mem_data_o;
   logic [2:0]  mem_addr_tag_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic        mem_data_tag_i;

   always #5 clk_i = ~clk_i;

   atomic_mem_master #(.WAIT_TIMEOUT(8)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .op_i           (op_i),
      .addr_i         (addr_i),
      .data_i         (data_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .result_o       (result_o),
      .misaligned_o   (misaligned_o),
      .timeout_o      (timeout_o),
      .mem_cyc_o      (mem_cyc_o),
      .mem_stb_o      (mem_stb_o),
      .mem_we_o       (mem_we_o),
      .mem_sel_o      (mem_sel_o),
      .mem_addr_o     (mem_addr_o),
      .mem_addr_tag_o (mem_addr_tag_o),
      .mem_data_o     (mem_data_o),
      .mem_ack_i      (mem_ack_i),
      .mem_data_i     (mem_data_i),
      .mem_data_tag_i (mem_data_tag_i)
   );

   // Responder model: zero-wait combinational ack, 256-word memory, one reservation
   logic        ack_en    = 1'b1;
   logic        clr_stats = 1'b0;
   logic        pre_en    = 1'b0;
   logic [31:0] pre_addr  = '0;
   logic [31:0] pre_data  = '0;
   logic [31:0] mem [0:255];
   logic        resv_v;
   logic [31:0] resv_a;
   int          rd_cnt, wr_cnt, hold_cnt, stb_cnt, cyc_cnt;
   logic [2:0]  rd_tag, wr_tag;
   logic [31:0] wr_data;

   assign mem_ack_i      = mem_cyc_o & mem_stb_o & ack_en;
   assign mem_data_i     = mem[mem_addr_o[9:2]];
   assign mem_data_tag_i = !(resv_v && (resv_a == mem_addr_o));

   always @(posedge clk_i) begin
      if (rst_i) resv_v <= 1'b0;
      if (clr_stats) begin
         rd_cnt <= 0; wr_cnt <= 0; hold_cnt <= 0; stb_cnt <= 0; cyc_cnt <= 0;
         rd_tag <= '0; wr_tag <= '0; wr_data <= '0;
         if (pre_en) mem[pre_addr[9:2]] <= pre_data;
      end else begin
         if (mem_cyc_o) cyc_cnt <= cyc_cnt + 1;
         if (mem_stb_o) stb_cnt <= stb_cnt + 1;
         if (mem_cyc_o && !mem_stb_o) hold_cnt <= hold_cnt + 1;
         if (mem_ack_i) begin
            if (mem_we_o) begin
               wr_cnt  <= wr_cnt + 1;
               wr_tag  <= mem_addr_tag_o;
               wr_data <= mem_data_o;
               if (mem_addr_tag_o[2:1] == 2'b01) begin
                  if (!mem_data_tag_i) mem[mem_addr_o[9:2]] <= mem_data_o;
                  resv_v <= 1'b0;
               end else begin
                  mem[mem_addr_o[9:2]] <= mem_data_o;
               end
            end else begin
               rd_cnt <= rd_cnt + 1;
               rd_tag <= mem_addr_tag_o;
               if (mem_addr_tag_o[2:1] == 2'b01) begin
                  resv_v <= 1'b1;
                  resv_a <= mem_addr_o;
               end
            end
         end
      end
   end

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issue one request, then scramble the inputs and wait (bounded) for done_o
   task automatic run_op(input amo_op_t op, input logic [31:0] addr, input logic [31:0] data,
                         input logic pre, input logic [31:0] pre_val,
                         output int lat, output logic [31:0] res, output logic mis, output logic tmo);
      @(negedge clk_i);
      req_i = 1'b1; op_i = op; addr_i = addr; data_i = data;
      clr_stats = 1'b1; pre_en = pre; pre_addr = addr; pre_data = pre_val;
      lat = 0;
      do begin
         @(negedge clk_i);
         req_i = 1'b0; clr_stats = 1'b0; pre_en = 1'b0;
         op_i = OP_SWAP; addr_i = 32'hFFFF_FFFC; data_i = 32'h5A5A_5A5A;
         lat++;
      end while (!done_o && lat < 40);
      res = result_o; mis = misaligned_o; tmo = timeout_o;
   endtask

   // AMO vectors: op, old memory word, rs2, expected written word (old word is rd)
   amo_op_t     t_op  [12] = '{OP_ADD, OP_MIN, OP_MAXU, OP_ADD, OP_MAX, OP_MINU,
                               OP_SWAP, OP_XOR, OP_AND, OP_OR, OP_MIN, OP_MAXU};
   logic [31:0] t_pre [12] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hF0F0_F0F0,
                               32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFE, 32'd7};
   logic [31:0] t_rs2 [12] = '{32'd3, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'hCAFE_F00D,
                               32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'd7};
   logic [31:0] t_exp [12] = '{32'd8, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1, 32'd1,
                               32'hCAFE_F00D, 32'h0FF0_0FF0, 32'hF000_F000, 32'hFFF0_FFF0,
                               32'hFFFF_FFFE, 32'd7};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] res, a;
      logic        mis, tmo, done_seen;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_bus", {28'b0, mem_cyc_o, mem_stb_o, mem_we_o, busy_o}, 32'h0);
      chk("rst_done", {29'b0, done_o, misaligned_o, timeout_o}, 32'h0);
      chk("rst_tag", {29'b0, mem_addr_tag_o}, 32'h0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_result", result_o, 32'h0);
      rst_i = 1'b0;

      // LR then SC (succeeds), then SC again (reservation gone)
      run_op(OP_LR, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, lat, res, mis, tmo);
      chk("lr_lat", lat, 2);
      chk("lr_result", res, 32'hDEAD_BEEF);
      chk("lr_rd_tag", {29'b0, rd_tag}, 32'b010);
      chk("lr_counts", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd1, 16'd0});
      chk("lr_flags", {30'b0, mis, tmo}, 32'h0);

      run_op(OP_SC, 32'h100, 32'h55, 1'b0, 32'h0, lat, res, mis, tmo);
      chk("sc1_lat", lat, 2);
      chk("sc1_result", res, 32'h0);
      chk("sc1_wr_tag", {29'b0, wr_tag}, 32'b011);
      chk("sc1_mem", mem[8'h40], 32'h55);

      run_op(OP_SC, 32'h100, 32'hAA, 1'b0, 32'h0, lat, res, mis, tmo);
      chk("sc2_result", res, 32'h1);
      chk("sc2_mem", mem[8'h40], 32'h55);
      chk("sc2_wr_cnt", wr_cnt, 1);

      // AMO table
      for (int i = 0; i < 12; i++) begin
         a = 32'h200 + 32'(i * 16);
         run_op(t_op[i], a, t_rs2[i], 1'b1, t_pre[i], lat, res, mis, tmo);
         chk($sformatf("amo%0d_lat", i), lat, 4);
         chk($sformatf("amo%0d_result", i), res, t_pre[i]);
         chk($sformatf("amo%0d_wdata", i), wr_data, t_exp[i]);
         chk($sformatf("amo%0d_mem", i), mem[a[9:2]], t_exp[i]);
         chk($sformatf("amo%0d_hold", i), hold_cnt, 1);
         chk($sformatf("amo%0d_tags", i), {26'b0, rd_tag, wr_tag}, {26'b0, 3'b100, 3'b101});
      end

      // Misaligned: done next cycle, no bus cycle
      run_op(OP_ADD, 32'h202, 32'h1, 1'b0, 32'h0, lat, res, mis, tmo);
      chk("mis_lat", lat, 1);
      chk("mis_flag", {31'b0, mis}, 32'h1);
      chk("mis_result", res, 32'h0);
      chk("mis_cyc", cyc_cnt, 0);

      // Timeout with WAIT_TIMEOUT=8 and a silent responder
      ack_en = 1'b0;
      run_op(OP_LR, 32'h100, 32'h0, 1'b0, 32'h0, lat, res, mis, tmo);
      chk("tmo_lat", lat, 9);
      chk("tmo_flag", {31'b0, tmo}, 32'h1);
      chk("tmo_result", res, 32'h0);
      chk("tmo_stb_cycles", stb_cnt, 8);
      ack_en = 1'b1;

      // Reset in the middle of an AMO (CALC state)
      @(negedge clk_i);
      req_i = 1'b1; op_i = OP_ADD; addr_i = 32'h2F0; data_i = 32'd7;
      clr_stats = 1'b1; pre_en = 1'b1; pre_addr = 32'h2F0; pre_data = 32'd100;
      @(negedge clk_i);
      req_i = 1'b0; clr_stats = 1'b0; pre_en = 1'b0;
      @(negedge clk_i);
      chk("calc_bus", {30'b0, mem_cyc_o, mem_stb_o}, 32'b10);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_mid_bus", {28'b0, mem_cyc_o, mem_stb_o, busy_o, done_o}, 32'h0);
      rst_i = 1'b0;
      done_seen = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         if (done_o) done_seen = 1'b1;
      end
      chk("rst_mid_no_done", {31'b0, done_seen}, 32'h0);
      chk("rst_mid_no_write", wr_cnt, 0);
      chk("rst_mid_mem", mem[8'hBC], 32'd100);

      // Normal operation after the mid-op reset
      run_op(OP_LR, 32'h100, 32'h0, 1'b1, 32'h600D_F00D, lat, res, mis, tmo);
      chk("post_rst_lat", lat, 2);
      chk("post_rst_result", res, 32'h600D_F00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
